alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational 32-bit ALU (operands A/B, 3-bit opcode, 32-bit result) between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready request and response channels, registered operands and result.
//  Sits between client blocks and a single ALU instance; the ALU itself stays outside this block.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  WIDTH    32  operand/result width; must equal ALU width
//  OPC_W    3   opcode width
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst          in   1                  synchronous, active-high reset
//  req_valid    in   [NUM_REQ]          request present, held until accepted
//  req_ready    out  [NUM_REQ]          one-hot (or zero) accept strobe
//  req_a        in   [NUM_REQ][WIDTH]   operand A per requester
//  req_b        in   [NUM_REQ][WIDTH]   operand B per requester
//  req_opcode   in   [NUM_REQ][OPC_W]   opcode per requester, passed through unmodified
//  rsp_valid    out  [NUM_REQ]          result available for the owning requester (one-hot or zero)
//  rsp_ready    in   [NUM_REQ]          requester consumes result
//  rsp_result   out  [WIDTH]            shared result bus, valid only where rsp_valid set
//  alu_a        out  [WIDTH]            to ALU A
//  alu_b        out  [WIDTH]            to ALU B
//  alu_opcode   out  [OPC_W]            to ALU opcode
//  alu_result   in   [WIDTH]            from ALU result (combinational path)
//  busy         out  1                  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1 (req 0 has top priority first), op/res regs=0,
//   req_ready=0, rsp_valid=0, rsp_result=0, alu_*=0, busy=0.
//  FSM: IDLE -> EXEC -> RESP -> (IDLE | EXEC).
//   IDLE: if any req_valid, grant g = first valid index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//    req_ready[g]=1 this cycle (combinational). Latch a/b/opcode and g; rr_ptr<=g; go to EXEC.
//   EXEC: alu_* driven from op regs (alu_* always driven from op regs). Capture alu_result into res reg; go to RESP.
//   RESP: rsp_valid[g]=1, rsp_result=res reg, both stable until rsp_ready[g].
//    On rsp_ready[g]: if any req_valid, grant a new request in the same cycle (same rr rule) and go to EXEC;
//    otherwise go to IDLE.
//  Latency: accept at cycle t -> rsp_valid at t+2. Peak throughput: one op per 2 cycles.
//  req_ready is asserted only in IDLE, or in RESP coincident with the response handshake; never otherwise.
//  rr_ptr updates only on accept. A requester whose response is pending may be re-granted in the handover cycle.
//  rsp_ready on non-owner bits is ignored. Deasserting req_valid before accept is a protocol violation.
//  Behaviour is undefined for that case, and the bench flags it.
//  Reset mid-operation: the in-flight op is discarded, no response is issued, and all reset values apply next cycle.
//  No arithmetic is done here; widths pass straight through. The ALU sets the opcode meaning (3'b011 = unsigned A<B, others = 0).
// STRUCTURE
//  alu_pkg: opcode enum (OP_LT=3'b011), arb_state_e {IDLE,EXEC,RESP}, WIDTH/OPC_W defaults.
//  Sub-module rr_arbiter #(NUM_REQ): inputs req vector and ptr, outputs one-hot grant and index.
//  Purely combinational; reused in both IDLE and RESP-handover grant.
// TESTING (bench instantiates this block plus the real ALU)
//  1 req_valid[0], A=5, B=9, op=3'b011 at t -> req_ready[0]@t, alu_a=5@t+1, rsp_valid[0]@t+2, rsp_result=1.
//  2 All 4 valid continuously, rsp_ready=4'hF -> grants 0,1,2,3,0 at 2-cycle spacing; no dup or skip.
//  3 Req1 granted, rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_result stable; req_ready stays 0 throughout.
//  4 op=3'b000, A=7, B=3 -> rsp_result=0; A=32'hFFFF_FFFF, B=1, op=011 -> 0 (unsigned compare).
//  5 rst pulsed during EXEC -> next cycle rsp_valid=0, busy=0; with req 2 and req 0 valid, req 0 granted first.
//  6 RESP handshake with req3 valid -> req_ready[3] in the same cycle, EXEC next, no IDLE bubble.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and defaults for the ALU sharing arbiter.
//   alu_op_e     : opcodes with a meaning known to this block's users
//   arb_state_e  : arbiter FSM states
//   idx_w()      : width of a requester index
package alu_share_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_OPC_W   = 3;

    // The ALU defines what each opcode means; only the compare is named here.
    typedef enum logic [2:0] {
        OP_LT = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index of the last grant; search starts at ptr_i+1
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester
//   any_o : at least one request present
module rr_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Offset 1..NUM_REQ so the last winner is checked last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters.
// Round-robin accept, registered operands and result, one op per 2 cycles peak.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : per-requester request handshake (ready one-hot)
//   req_a_i/b_i/opcode_i  : per-requester operands and opcode
//   rsp_valid_o/ready_i   : per-requester response handshake (valid one-hot)
//   rsp_result_o          : shared result bus
//   alu_a_o/b_o/opcode_o  : to the ALU, straight from the operand registers
//   alu_result_i          : from the ALU
//   busy_o                : FSM not idle
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPC_W   = DEF_OPC_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_a_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_b_i,
    input  logic [NUM_REQ-1:0][OPC_W-1:0]    req_opcode_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    input  logic [NUM_REQ-1:0]               rsp_ready_i,
    output logic [WIDTH-1:0]                 rsp_result_o,
    output logic [WIDTH-1:0]                 alu_a_o,
    output logic [WIDTH-1:0]                 alu_b_o,
    output logic [OPC_W-1:0]                 alu_opcode_o,
    input  logic [WIDTH-1:0]                 alu_result_i,
    output logic                             busy_o
);

    // state | meaning
    // IDLE  | nothing in flight, accept any request
    // EXEC  | operands registered and on the ALU, capture result
    // RESP  | result held for owner; handshake may hand over to a new request

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        accept      = 1'b0;
        req_ready_o = '0;
        rsp_valid_o = '0;

        case (state_q)
            IDLE: begin
                accept = gnt_any;
            end
            EXEC: begin
                res_d   = alu_result_i;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                // Handover: the completing response and the next accept share a cycle.
                if (rsp_ready_i[owner_q]) begin
                    if (gnt_any) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            req_ready_o = gnt;
            a_d         = req_a_i[gnt_idx];
            b_d         = req_b_i[gnt_idx];
            op_d        = req_opcode_i[gnt_idx];
            owner_d     = gnt_idx;
            rr_ptr_d    = gnt_idx;
            state_d     = EXEC;
        end
    end

    assign rsp_result_o = res_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_opcode_o = op_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int O = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0][W-1:0]  req_a, req_b;
    logic [N-1:0][O-1:0]  req_op;
    logic [W-1:0]         rsp_result, alu_a, alu_b, alu_result;
    logic [O-1:0]         alu_opcode;
    logic                 busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .OPC_W(O)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_opcode_i (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result),
        .busy_o       (busy)
    );

    // Reference ALU: 3'b011 is unsigned A<B, everything else yields 0.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [O-1:0] op);
        return (op == 3'b011 && a < b) ? 32'd1 : 32'd0;
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_opcode);

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [O-1:0] op;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
    } sb_t;

    vec_t         tbl[7];
    sb_t          sbq[$];
    sb_t          sb_e;
    logic [N-1:0] prev_pend = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Advance one clock; requests accepted in the cycle just ended are withdrawn.
    task automatic step();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            prev_pend = '0;
        end else begin
            if ((prev_pend & ~req_valid) != 0) begin
                nerr++;
                $display("FAIL protocol: req_valid dropped before accept, bits %b", prev_pend & ~req_valid);
            end
            prev_pend = req_valid & ~req_ready;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 0) begin
                nerr++;
                $display("FAIL req_ready_onehot: got %b with req_valid %b", req_ready, req_valid);
            end
            if ($countones(rsp_valid) > 1) begin
                nerr++;
                $display("FAIL rsp_valid_onehot: got %b", rsp_valid);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    sbq.push_back('{i, alu_model(req_a[i], req_b[i], req_op[i])});
            end
            for (int j = 0; j < N; j++) begin
                if (rsp_valid[j] && rsp_ready[j]) begin
                    if (sbq.size() == 0) begin
                        nerr++;
                        $display("FAIL sb_unexpected: response on %0d with nothing outstanding", j);
                    end else begin
                        sb_e = sbq.pop_front();
                        chk("sb_owner", 64'(j), 64'(sb_e.idx));
                        chk("sb_result", 64'(rsp_result), 64'(sb_e.res));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        tbl[0] = '{0, 32'd5,          32'd9,          3'b011, 32'd1};
        tbl[1] = '{1, 32'd7,          32'd3,          3'b000, 32'd0};
        tbl[2] = '{2, 32'hFFFF_FFFF,  32'd1,          3'b011, 32'd0};
        tbl[3] = '{3, 32'd1,          32'hFFFF_FFFF,  3'b011, 32'd1};
        tbl[4] = '{1, 32'd9,          32'd9,          3'b011, 32'd0};
        tbl[5] = '{2, 32'd0,          32'd1,          3'b111, 32'd0};
        tbl[6] = '{0, 32'd0,          32'd1,          3'b011, 32'd1};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);

        // Single op latency: accept t, ALU operands t+1, response t+2
        req_a[0] = 32'd5; req_b[0] = 32'd9; req_op[0] = 3'b011; req_valid[0] = 1'b1;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'b0001);
        step(); #1;
        chk("t1_alu_a", 64'(alu_a), 64'd5);
        chk("t1_alu_opcode", 64'(alu_opcode), 64'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
        chk("t1_ready_exec", 64'(req_ready), 64'd0);
        step(); #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("t1_rsp_result", 64'(rsp_result), 64'd1);
        step(); #1;
        chk("t1_idle", 64'(busy), 64'd0);

        // Table-driven single operations
        for (int v = 0; v < 7; v++) begin
            req_a[tbl[v].idx]     = tbl[v].a;
            req_b[tbl[v].idx]     = tbl[v].b;
            req_op[tbl[v].idx]    = tbl[v].op;
            req_valid[tbl[v].idx] = 1'b1;
            #1;
            found = 0;
            for (int k = 0; k < 20 && found == 0; k++) begin
                if (req_ready[tbl[v].idx]) found = 1;
                else begin step(); #1; end
            end
            chk("tbl_accept", 64'(found), 64'd1);
            step(); #1;
            found = 0;
            for (int k = 0; k < 20 && found == 0; k++) begin
                if (rsp_valid[tbl[v].idx]) found = 1;
                else begin step(); #1; end
            end
            chk("tbl_rsp_seen", 64'(found), 64'd1);
            chk("tbl_rsp_valid", 64'(rsp_valid), 64'(1 << tbl[v].idx));
            chk("tbl_result", 64'(rsp_result), 64'(tbl[v].exp));
            step(); #1;
        end

        // All requesters continuously valid: grants 0,1,2,3,0,... two cycles apart
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 32'(i); req_b[i] = 32'd2; req_op[i] = 3'b011;
        end
        req_valid = '1;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("t2_grant", 64'(req_ready), (c % 2 == 0) ? 64'(1 << ((c / 2) % N)) : 64'd0);
            step();
            if (c < 8) req_valid = '1;
            #1;
        end
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (req_valid == '0 && !busy) found = 1;
            else begin step(); #1; end
        end
        chk("t2_drained", 64'(found), 64'd1);

        // Stalled response, then handover to req2, then handover to req3
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        req_a[1] = 32'd3; req_b[1] = 32'd4; req_op[1] = 3'b011; req_valid[1] = 1'b1;
        rsp_ready = '0;
        #1;
        chk("t3_accept1", 64'(req_ready), 64'b0010);
        step(); #1;
        step(); #1;
        req_a[2] = 32'd10; req_b[2] = 32'd2; req_op[2] = 3'b011; req_valid[2] = 1'b1;
        rsp_ready = 4'b1101;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_rsp_hold", 64'(rsp_valid), 64'b0010);
            chk("t3_result_hold", 64'(rsp_result), 64'd1);
            chk("t3_no_ready", 64'(req_ready), 64'd0);
            step(); #1;
        end
        rsp_ready = 4'b0010;
        #1;
        chk("t3_handover_ready", 64'(req_ready), 64'b0100);
        chk("t3_handover_rsp", 64'(rsp_valid), 64'b0010);
        step(); #1;
        chk("t3_exec_busy", 64'(busy), 64'd1);
        chk("t3_exec_rsp", 64'(rsp_valid), 64'd0);
        chk("t3_exec_alu_a", 64'(alu_a), 64'd10);
        step();
        rsp_ready = '0;
        req_a[3] = 32'd2; req_b[3] = 32'd3; req_op[3] = 3'b011; req_valid[3] = 1'b1;
        #1;
        chk("t6_rsp2", 64'(rsp_valid), 64'b0100);
        chk("t6_result2", 64'(rsp_result), 64'd0);
        chk("t6_no_ready", 64'(req_ready), 64'd0);
        rsp_ready = 4'b0100;
        #1;
        chk("t6_ready3", 64'(req_ready), 64'b1000);
        step(); #1;
        chk("t6_no_bubble", 64'(busy), 64'd1);
        chk("t6_exec_rsp", 64'(rsp_valid), 64'd0);
        chk("t6_alu_a", 64'(alu_a), 64'd2);
        rsp_ready = '1;
        step(); #1;
        chk("t6_rsp3", 64'(rsp_valid), 64'b1000);
        chk("t6_result3", 64'(rsp_result), 64'd1);
        step(); #1;
        chk("t6_idle", 64'(busy), 64'd0);

        // Reset during EXEC discards the op and restores the pointer
        req_a[1] = 32'd1; req_b[1] = 32'd2; req_op[1] = 3'b011; req_valid[1] = 1'b1;
        #1;
        chk("t5_accept1", 64'(req_ready), 64'b0010);
        step(); #1;
        chk("t5_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        req_a[0] = 32'd4; req_b[0] = 32'd8; req_op[0] = 3'b011;
        req_a[2] = 32'd8; req_b[2] = 32'd4; req_op[2] = 3'b011;
        req_valid = 4'b0101;
        #1;
        chk("t5_grant0", 64'(req_ready), 64'b0001);
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (req_valid == '0 && !busy) found = 1;
            else begin step(); #1; end
        end
        chk("t5_drained", 64'(found), 64'd1);

        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
